stopwatch_controller: RTL and testbench
=======================================

// Module: stopwatch_controller
//
// PURPOSE
// - Sequences the mm:ss stopwatch datapath that feeds the 4-digit display controller.
// - Owns the button synchronisers and debouncers, the run/pause/adjust mode FSM,
//   the 1 Hz / 2 Hz tick prescalers and the BCD time counters.
// - Drives the four BCD digit inputs of the display controller, plus a per-digit blank mask.
//
// PARAMETERS
// - CLK_HZ           100_000_000  clk frequency; 1 Hz tick = CLK_HZ cycles, 2 Hz = CLK_HZ/2 (even, >=4)
// - DEBOUNCE_CYCLES  1_000_000    consecutive stable synchronised cycles to accept a button level (>=1)
//
// PORTS
// - clk            in   1  system clock
// - reset          in   1  synchronous, active-high reset
// - btn_pause      in   1  raw start/pause button, async, bouncy
// - btn_rst        in   1  raw clear button, async, bouncy
// - sw_adjust      in   1  raw adjust-mode switch, async (2-FF sync only)
// - sw_sel         in   1  raw adjust field select: 0 = seconds, 1 = minutes (2-FF sync only)
// - minutes_tens   out  4  BCD 0..5
// - minutes_units  out  4  BCD 0..9
// - seconds_tens   out  4  BCD 0..5
// - seconds_units  out  4  BCD 0..9
// - blank_mask     out  4  1 = blank digit; [3]=min tens .. [0]=sec units
// - running        out  1  1 while FSM is in RUN
// - tick_1hz       out  1  one-cycle pulse on each counted second
//
// BEHAVIOUR
// - Reset: all digits 0, blank_mask 0, running 0, tick_1hz 0, FSM IDLE, prescalers 0, debouncers released.
// - Inputs: 2-FF synchronisers on all four inputs.
// - Debounce: the accepted level changes after DEBOUNCE_CYCLES identical synchronised samples.
// - Press event: one-cycle pulse on the accepted 0->1 edge.
// - Press latency: raw edge -> pulse = 2 + DEBOUNCE_CYCLES cycles.
// - FSM states: IDLE, RUN, PAUSE, ADJUST. Priority order: rst press > sw_adjust > pause press.
//   - Any state, rst press: digits <= 0, prescalers <= 0, next = IDLE.
//   - IDLE/RUN/PAUSE with sw_adjust=1 -> ADJUST.
//   - ADJUST with sw_adjust=0 -> PAUSE.
//   - IDLE or PAUSE, pause press -> RUN.
//   - RUN, pause press -> PAUSE.
// - 1 Hz prescaler: counts only in RUN and is cleared in every other state.
//   - tick_1hz pulses when the prescaler = CLK_HZ-1; the prescaler then wraps to 0.
//   - First tick after entering RUN comes CLK_HZ cycles later.
// - Tick: BCD increment of mm:ss with ripple carry (s_units 9->0, s_tens 5->0, m_units 9->0, m_tens 5->0).
//   - 59:59 wraps to 00:00 and the stopwatch keeps running.
//   - Digits update in the same cycle tick_1hz is high.
// - Pause press in the same cycle as a tick: the tick is applied, then the FSM goes to PAUSE.
// - 2 Hz adjust prescaler: counts only in ADJUST and is cleared elsewhere.
//   - Every CLK_HZ/2 cycles it increments the selected 2-digit field as a mod-60 BCD value.
//   - No carry into the other field, and tick_1hz is not asserted.
//   - sw_sel change takes effect on the next adjust step; the prescaler is not reset.
// - Pause presses are ignored in ADJUST.
// - rst press in ADJUST clears the digits and goes to IDLE, even while sw_adjust=1.
//   - Re-entry to ADJUST follows on the next cycle.
// - BCD digits never exceed their legal range; no illegal input path exists.
//
// CONFIGURATION
// - Macro BLINK_EN.
// - Defined: in ADJUST, the selected field's two blank_mask bits toggle every CLK_HZ/4 cycles.
//   - Phase counter cleared on entering ADJUST; blanking starts at 0 (visible first).
//   - blank_mask = 0 in all other states.
// - Undefined: blank_mask tied to 4'b0000, no blink counter is synthesised.
//
// TESTING  (bench: CLK_HZ=8, DEBOUNCE_CYCLES=2)
// - Reset, then pause press -> running=1 at pulse+1; tick_1hz after 8 cycles; digits 00:01. 5 more ticks -> 00:06.
// - Adjust sw_sel=1 to 59, sw_sel=0 to 59, sw_adjust=0, pause press, 1 tick -> 00:00, running stays 1.
// - RUN at 00:03, pause press -> running=0; digits frozen 40 cycles; press again -> 00:04 exactly 8 cycles after RUN.
// - RUN at 12:34, rst press -> next cycle 00:00, IDLE, running=0; no tick_1hz for 40 cycles.
// - btn_pause 1-cycle glitches every 2 cycles for 30 cycles -> no press event, state unchanged.
// - IDLE, sw_adjust=1, sw_sel=1 -> minutes +1 every 4 cycles, 59->00 with seconds unchanged.
//   - With BLINK_EN, blank_mask alternates 0000/1100 every 2 cycles.

Source files
------------

// File: rtl/stopwatch_controller.sv
// -----------------------------------------------------------------------------
// stopwatch_controller
//
// Purpose:
//   Sequences the mm:ss stopwatch that feeds a 4-digit display controller.
//   It contains the button synchronisers and debouncers and the IDLE/RUN/
//   PAUSE/ADJUST mode FSM. It also holds the 1 Hz run prescaler, the 2 Hz
//   adjust prescaler and the BCD time counters.
//
// Configuration:
//   BLINK_EN  When defined, the selected field's two digits blink in ADJUST.
//             The blink toggles every CLK_HZ/4 cycles, and the digits start
//             out visible. When undefined, blank_mask is constant 4'b0000 and
//             no blink counter exists.
//
// Parameters:
//   CLK_HZ           clk frequency. 1 Hz tick = CLK_HZ cycles. Must be even and >= 4.
//   DEBOUNCE_CYCLES  number of identical synchronised samples needed before a
//                    new button level is accepted (>= 1).
//
// Ports:
//   clk, reset                    system clock; synchronous active-high reset
//   btn_pause, btn_rst            raw bouncy buttons (start/pause, clear)
//   sw_adjust, sw_sel             raw switches (adjust mode; 0=seconds 1=minutes)
//   minutes_tens .. seconds_units BCD digits to the display controller
//   blank_mask                    1 = blank digit, [3]=min tens .. [0]=sec units
//   running                       high while the FSM is in RUN
//   tick_1hz                      one-cycle pulse on each counted second
// -----------------------------------------------------------------------------

// Two-flop synchroniser, level debouncer and rising-edge press detector.
// The press pulse appears 2 + DEBOUNCE_CYCLES cycles after the raw edge.
module stopwatch_debounce #(
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        // Any sample agreeing with the accepted level restarts the run.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module stopwatch_controller #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_pause,
  input  logic       btn_rst,
  input  logic       sw_adjust,
  input  logic       sw_sel,
  output logic [3:0] minutes_tens,
  output logic [3:0] minutes_units,
  output logic [3:0] seconds_tens,
  output logic [3:0] seconds_units,
  output logic [3:0] blank_mask,
  output logic       running,
  output logic       tick_1hz
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSE  = 2'd2;
  localparam logic [1:0] ST_ADJUST = 2'd3;

  localparam int HALF_HZ = CLK_HZ / 2;
  localparam int PW      = $clog2(CLK_HZ);
  localparam int AW      = (HALF_HZ > 1) ? $clog2(HALF_HZ) : 1;
  localparam logic [PW-1:0] PRESC_1HZ_LAST = PW'(CLK_HZ - 1);
  localparam logic [AW-1:0] PRESC_ADJ_LAST = AW'(HALF_HZ - 1);

  logic          pause_press;
  logic          rst_press;
  logic [1:0]    adjust_meta;
  logic [1:0]    sel_meta;
  logic          adjust_sync;
  logic          sel_sync;
  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [PW-1:0] presc_1hz;
  logic [AW-1:0] presc_adj;
  logic [7:0]    minutes;  // {tens, units} BCD
  logic [7:0]    seconds;  // {tens, units} BCD

  // Mod-60 BCD increment of a {tens, units} field.
  function automatic logic [7:0] inc_mod60(input logic [7:0] f);
    if (f[3:0] != 4'd9) return {f[7:4], f[3:0] + 4'd1};
    if (f[7:4] != 4'd5) return {f[7:4] + 4'd1, 4'd0};
    return 8'h00;
  endfunction

  stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_pause),
    .press (pause_press)
  );

  stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_rst),
    .press (rst_press)
  );

  // Switches are level controls and need only metastability protection.
  always_ff @(posedge clk) begin
    if (reset) begin
      adjust_meta <= 2'b00;
      sel_meta    <= 2'b00;
    end else begin
      adjust_meta <= {adjust_meta[0], sw_adjust};
      sel_meta    <= {sel_meta[0], sw_sel};
    end
  end

  assign adjust_sync = adjust_meta[1];
  assign sel_sync    = sel_meta[1];

  // The clear button has priority and is handled in the sequential block.
  // The adjust switch comes next, then the pause press.
  always_comb begin
    // NOTE: assign a default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    if (adjust_sync && state != ST_ADJUST) begin
      state_next = ST_ADJUST;
    end else if (state == ST_ADJUST && !adjust_sync) begin
      state_next = ST_PAUSE;
    end else if (pause_press) begin
      if (state == ST_IDLE || state == ST_PAUSE) state_next = ST_RUN;
      else if (state == ST_RUN)                  state_next = ST_PAUSE;
    end
  end

  // NOTE: reset is synchronous; it is only acted on at a clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      presc_1hz <= '0;
      presc_adj <= '0;
      minutes   <= 8'h00;
      seconds   <= 8'h00;
      tick_1hz  <= 1'b0;
    end else begin
      tick_1hz <= 1'b0;
      if (rst_press) begin
        state     <= ST_IDLE;
        presc_1hz <= '0;
        presc_adj <= '0;
        minutes   <= 8'h00;
        seconds   <= 8'h00;
      end else begin
        // A tick due on the same edge as a pause press or a mode change is
        // still applied, because the prescaler follows the current state.
        if (state == ST_RUN) begin
          if (presc_1hz == PRESC_1HZ_LAST) begin
            presc_1hz <= '0;
            tick_1hz  <= 1'b1;
            seconds   <= inc_mod60(seconds);
            if (seconds == 8'h59) minutes <= inc_mod60(minutes);
          end else begin
            presc_1hz <= presc_1hz + PW'(1);
          end
        end else begin
          presc_1hz <= '0;
        end

        // Adjust steps touch only the selected field, so no carry is applied.
        if (state == ST_ADJUST) begin
          if (presc_adj == PRESC_ADJ_LAST) begin
            presc_adj <= '0;
            if (sel_sync) minutes <= inc_mod60(minutes);
            else          seconds <= inc_mod60(seconds);
          end else begin
            presc_adj <= presc_adj + AW'(1);
          end
        end else begin
          presc_adj <= '0;
        end

        state <= state_next;
      end
    end
  end

`ifdef BLINK_EN
  localparam int QUARTER_HZ = CLK_HZ / 4;
  localparam int BW         = (QUARTER_HZ > 1) ? $clog2(QUARTER_HZ) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(QUARTER_HZ - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // The phase restarts at "visible" on every entry into ADJUST.
  always_ff @(posedge clk) begin
    if (reset || rst_press || state != ST_ADJUST) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign blank_mask = (state == ST_ADJUST && blink_phase) ?
                      (sel_sync ? 4'b1100 : 4'b0011) : 4'b0000;
`else
  assign blank_mask = 4'b0000;
`endif

  assign running       = (state == ST_RUN);
  assign minutes_tens  = minutes[7:4];
  assign minutes_units = minutes[3:0];
  assign seconds_tens  = seconds[7:4];
  assign seconds_units = seconds[3:0];
endmodule

// File: tb/tb_stopwatch_controller.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_controller
//
// Self-checking bench for stopwatch_controller with CLK_HZ=8 and
// DEBOUNCE_CYCLES=2.
//
// A reference model runs on every rising edge. It keeps elapsed time as an
// integer number of seconds and the mode as an enum. For each cycle it pushes
// the expected output snapshot into a queue. A monitor pops that queue on the
// falling edge and compares the snapshot with the DUT outputs.
//
// The main process drives directed scenarios and then random stimulus. It
// also makes a few checks of its own against constants.
// -----------------------------------------------------------------------------
module tb_stopwatch_controller;
  localparam int CLK_HZ = 8;
  localparam int DEB    = 2;
  localparam int HALF   = CLK_HZ / 2;
  localparam int QTR    = CLK_HZ / 4;
  localparam int HLEN   = DEB + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_pause = 1'b0;
  logic       btn_rst = 1'b0;
  logic       sw_adjust = 1'b0;
  logic       sw_sel = 1'b0;
  logic [3:0] minutes_tens, minutes_units, seconds_tens, seconds_units;
  logic [3:0] blank_mask;
  logic       running, tick_1hz;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] mt, mu, st, su;
    logic [3:0] mask;
    logic       run;
    logic       tick;
  } snap_t;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_ADJ} mode_t;

  snap_t exp_q[$];

  always #5 clk = ~clk;

  stopwatch_controller #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_pause     (btn_pause),
    .btn_rst       (btn_rst),
    .sw_adjust     (sw_adjust),
    .sw_sel        (sw_sel),
    .minutes_tens  (minutes_tens),
    .minutes_units (minutes_units),
    .seconds_tens  (seconds_tens),
    .seconds_units (seconds_units),
    .blank_mask    (blank_mask),
    .running       (running),
    .tick_1hz      (tick_1hz)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {minutes_tens, minutes_units, seconds_tens, seconds_units};
  endfunction

  // ---------------- reference model ----------------
  mode_t          mode;
  int             secs, run_age, adj_age;
  bit             phase;
  bit [HLEN-1:0]  hp, hr, ha, hs;  // raw input history, bit 0 = newest sample
  bit             acc_p, acc_r, ev_p, ev_r, tick_m;

  task automatic model_step();
    bit    do_rst, do_pause, adj_on, sel_on;
    int    mins;
    snap_t s;
    if (reset) begin
      mode = M_IDLE; secs = 0; run_age = 0; adj_age = 0; phase = 0;
      hp = '0; hr = '0; ha = '0; hs = '0;
      acc_p = 0; acc_r = 0; ev_p = 0; ev_r = 0; tick_m = 0;
    end else begin
      // Presses recognised last cycle act now.
      do_rst   = ev_r;
      do_pause = ev_p;
      hp = {hp[HLEN-2:0], btn_pause};
      hr = {hr[HLEN-2:0], btn_rst};
      ha = {ha[HLEN-2:0], sw_adjust};
      hs = {hs[HLEN-2:0], sw_sel};
      // The FSM sees switch levels from two cycles ago.
      adj_on = ha[2];
      sel_on = hs[2];
      // A button level is accepted after DEB consecutive samples that all
      // differ from the accepted level. The samples are two cycles old.
      ev_p = 0;
      if (hp[HLEN-1:2] == {DEB{~acc_p}}) begin acc_p = ~acc_p; ev_p = acc_p; end
      ev_r = 0;
      if (hr[HLEN-1:2] == {DEB{~acc_r}}) begin acc_r = ~acc_r; ev_r = acc_r; end

      tick_m = 0;
      if (do_rst) begin
        secs = 0; run_age = 0; adj_age = 0; phase = 0; mode = M_IDLE;
      end else begin
        if (mode == M_RUN) begin
          run_age++;
          if (run_age % CLK_HZ == 0) begin tick_m = 1; secs = (secs + 1) % 3600; end
        end else run_age = 0;
        if (mode == M_ADJ) begin
          adj_age++;
          phase = ((adj_age / QTR) % 2) == 1;
          if (adj_age % HALF == 0) begin
            if (sel_on) secs = (((secs / 60) + 1) % 60) * 60 + secs % 60;
            else        secs = (secs / 60) * 60 + ((secs % 60) + 1) % 60;
          end
        end else begin
          adj_age = 0; phase = 0;
        end
        if (mode != M_ADJ && adj_on)                          mode = M_ADJ;
        else if (mode == M_ADJ && !adj_on)                    mode = M_PAUSE;
        else if (do_pause && (mode == M_IDLE || mode == M_PAUSE)) mode = M_RUN;
        else if (do_pause && mode == M_RUN)                   mode = M_PAUSE;
      end
    end
    mins   = secs / 60;
    s.mt   = 4'(mins / 10);
    s.mu   = 4'(mins % 10);
    s.st   = 4'((secs % 60) / 10);
    s.su   = 4'(secs % 10);
    s.run  = (mode == M_RUN);
    s.tick = tick_m;
`ifdef BLINK_EN
    s.mask = (mode == M_ADJ && phase) ? (hs[1] ? 4'b1100 : 4'b0011) : 4'b0000;
`else
    s.mask = 4'b0000;
`endif
    exp_q.push_back(s);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- monitor ----------------
  initial begin
    snap_t exp_s, act_s;
    forever begin
      @(negedge clk);
      act_s = {minutes_tens, minutes_units, seconds_tens, seconds_units,
               blank_mask, running, tick_1hz};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: no expected snapshot queued");
      end else begin
        exp_s = exp_q.pop_front();
        if (act_s !== exp_s) begin
          errors++;
          $display("FAIL snapshot @%0t: got %h%h:%h%h mask=%b run=%b tick=%b expected %h%h:%h%h mask=%b run=%b tick=%b",
                   $time, act_s.mt, act_s.mu, act_s.st, act_s.su, act_s.mask, act_s.run, act_s.tick,
                   exp_s.mt, exp_s.mu, exp_s.st, exp_s.su, exp_s.mask, exp_s.run, exp_s.tick);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_pause();
    btn_pause = 1'b1; cycles(6);
    btn_pause = 1'b0; cycles(6);
  endtask

  task automatic press_rst();
    btn_rst = 1'b1; cycles(6);
    btn_rst = 1'b0; cycles(6);
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!tick_1hz && n < 40);
    if (!tick_1hz) begin
      checks++; errors++;
      $display("FAIL %s: tick_1hz not seen within 40 cycles", name);
    end
  endtask

  task automatic wait_field(input string name, input bit use_min, input logic [7:0] target);
    int n = 0;
    logic [7:0] f;
    do begin
      @(negedge clk); n++;
      f = use_min ? {minutes_tens, minutes_units} : {seconds_tens, seconds_units};
    end while (f != target && n < 300);
    if (f != target) begin
      checks++; errors++;
      $display("FAIL %s: field %h never reached %h", name, f, target);
    end
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [7:0] f0;
    cycles(3);
    reset = 1'b0;
    check("reset_digits", 32'(digits()), 32'h0000);
    check("reset_flags", 32'({blank_mask, running, tick_1hz}), 32'h0);

    // Start and count to 00:06.
    press_pause();
    wait_tick("first_tick");
    check("first_tick_digits", 32'(digits()), 32'h0001);
    check("running_after_start", 32'(running), 32'h1);
    repeat (5) wait_tick("run_tick");
    check("six_seconds", 32'(digits()), 32'h0006);

    // Adjust to 59:59, leave adjust, then run through the wrap.
    sw_adjust = 1'b1; sw_sel = 1'b1;
    wait_field("adj_min_59", 1'b1, 8'h59);
    sw_sel = 1'b0;
    wait_field("adj_sec_59", 1'b0, 8'h59);
    sw_adjust = 1'b0;
    cycles(4);
    check("adjusted_5959", 32'(digits()), 32'h5959);
    check("paused_after_adjust", 32'(running), 32'h0);
    press_pause();
    wait_tick("wrap_tick");
    check("wrap_digits", 32'(digits()), 32'h0000);
    cycles(3);
    check("running_after_wrap", 32'(running), 32'h1);

    // Pause at 00:03, hold, resume: the next tick comes 8 cycles after RUN.
    repeat (3) wait_tick("to_three");
    press_pause();
    check("paused", 32'(running), 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("frozen_digits", 32'(digits()), 32'h0003);
    end
    btn_pause = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!running && n < 20);
    check("resume_seen", 32'(running), 32'h1);
    btn_pause = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!tick_1hz && n < 20);
    check("resume_tick_latency", 32'(n), 32'd8);
    check("resumed_digits", 32'(digits()), 32'h0004);

    // Set 12:34, run, then clear.
    sw_adjust = 1'b1; sw_sel = 1'b1;
    wait_field("adj_min_12", 1'b1, 8'h12);
    sw_sel = 1'b0;
    wait_field("adj_sec_34", 1'b0, 8'h34);
    sw_adjust = 1'b0;
    cycles(4);
    press_pause();
    press_rst();
    check("cleared_digits", 32'(digits()), 32'h0000);
    check("cleared_idle", 32'(running), 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("no_tick_in_idle", 32'(tick_1hz), 32'h0);
    end

    // Glitchy pause button must not start the stopwatch.
    for (int i = 0; i < 15; i++) begin
      btn_pause = 1'b1; cycles(1);
      btn_pause = 1'b0; cycles(1);
    end
    cycles(8);
    check("glitch_ignored", 32'({running, digits()}), 32'h0);

    // Minutes adjust from IDLE: 4-cycle step, 59 -> 00, seconds untouched.
    sw_adjust = 1'b1; sw_sel = 1'b0;
    wait_field("adj_sec_07", 1'b0, 8'h07);
    sw_sel = 1'b1;
    f0 = {minutes_tens, minutes_units}; n = 0;
    do begin @(negedge clk); n++; end while ({minutes_tens, minutes_units} == f0 && n < 20);
    f0 = {minutes_tens, minutes_units}; n = 0;
    do begin @(negedge clk); n++; end while ({minutes_tens, minutes_units} == f0 && n < 20);
    check("adjust_step_period", 32'(n), 32'd4);
    wait_field("min_59", 1'b1, 8'h59);
    wait_field("min_wrap", 1'b1, 8'h00);
    check("seconds_kept_on_wrap", 32'(digits()), 32'h0007);
    press_rst();
    cycles(4);
    sw_adjust = 1'b0;
    cycles(6);

    // Random phase, with one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) btn_pause = ~btn_pause;
      if ($urandom_range(0, 90) == 0) btn_rst   = ~btn_rst;
      if ($urandom_range(0, 80) == 0) sw_adjust = ~sw_adjust;
      if ($urandom_range(0, 20) == 0) sw_sel    = ~sw_sel;
      reset = (i >= 1500 && i < 1502);
      @(negedge clk);
    end
    btn_pause = 1'b0; btn_rst = 1'b0; sw_adjust = 1'b0; sw_sel = 1'b0;
    cycles(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
